way_refill_ctrl: RTL and testbench
==================================

Name: way_refill_ctrl

Overview:
- Blocking miss/refill controller for a 4-way set-associative cache set array.
- Takes tag-lookup results, drives the hit/request/index inputs of the 4-way PLRU, and issues a memory refill on a miss.
- Writes the returned line into the victim way it captured when the miss was accepted.
- Sits between the tag-compare stage, the PLRU, and the memory request/response channel.

Parameters:
- ADDR_WIDTH, 32, line address width carried with each lookup.
- LINE_WIDTH, 128, refill data width, one beat per line.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_lkup_vld  in  1  lookup valid.
- i_lkup_addr  in  ADDR_WIDTH  lookup line address.
- i_lkup_hit_vec  in  4  per-way hit bits, one-hot or zero.
- o_lkup_rdy  out  1  lookup accepted when vld&rdy.
- o_plru_hit  out  1  to PLRU hit input.
- o_plru_hit_idx  out  2  to PLRU hit index.
- o_plru_req  out  1  to PLRU replace-request input.
- i_plru_replace_idx  in  2  PLRU current victim index.
- o_mem_req_vld  out  1  refill request valid.
- o_mem_req_addr  out  ADDR_WIDTH  refill address.
- i_mem_req_rdy  in  1  memory accepts request.
- i_mem_rsp_vld  in  1  refill data valid, always accepted.
- i_mem_rsp_data  in  LINE_WIDTH  refill data.
- o_fill_vld  out  1  one-cycle way write strobe.
- o_fill_way  out  2  way being written.
- o_fill_addr  out  ADDR_WIDTH  line address written.
- o_fill_data  out  LINE_WIDTH  line data written.
- o_multi_hit_err  out  1  sticky flag, set on a multi-hot hit vector.

Behaviour:
- FSM states:
  - IDLE, reset state.
  - REQ, o_mem_req_vld=1.
  - WAIT, awaiting response.
  - FILL, o_fill_vld=1.
- Reset values:
  - State IDLE.
  - o_lkup_rdy=1.
  - All other outputs and registers 0, including o_multi_hit_err.
- o_lkup_rdy=1 only in IDLE.
- Lookups are not accepted in any other state; upstream holds vld/addr.
- Accepted lookup with a nonzero hit vector:
  - Same cycle: o_plru_hit=1, o_plru_hit_idx = lowest set bit index.
  - FSM stays IDLE.
  - If more than one bit is set, o_multi_hit_err is set. It clears only on reset.
- Accepted lookup with hit vector 0 (miss):
  - Same cycle: o_plru_req=1, o_plru_hit=0.
  - i_plru_replace_idx is latched into the victim register that cycle. It is the pre-update value, because the PLRU updates at the clock edge.
  - i_lkup_addr is latched.
  - Next state REQ.
- o_plru_hit and o_plru_req are combinational, never both 1, and both 0 outside IDLE.
- REQ: o_mem_req_vld=1 and o_mem_req_addr = latched address. These hold stable until i_mem_req_rdy. On vld&rdy, next state WAIT.
- Response timing:
  - WAIT: on i_mem_rsp_vld, data is registered and next state is FILL.
  - A response arriving in REQ, before handshake, is ignored and is a protocol error.
  - A response in the same cycle as the REQ handshake is not expected.
- FILL lasts one cycle:
  - o_fill_vld=1.
  - o_fill_way = victim, o_fill_addr = latched address, o_fill_data = registered data.
  - Next state IDLE. A new lookup can be accepted the cycle after FILL.
- Minimum miss latency, accept to fill strobe: 3 cycles (rdy and rsp both immediate).
- Reset mid-refill:
  - Asynchronous return to IDLE.
  - A pending memory response after reset is ignored, since the FSM is in IDLE.
- No address/data registers change outside their load conditions.

Optional Feature:
- Macro: WAY_REFILL_INVALID_FIRST_EN.
- With the macro:
  - Adds input i_way_valid [4], the valid bits of the looked-up set.
  - On a miss with any invalid way, the victim is the lowest invalid way. It is signalled as o_plru_hit=1 with o_plru_hit_idx = that way, so it becomes MRU, and o_plru_req=0.
  - If all ways are valid, behaviour is as without the macro.
- Without the macro: the port is absent and the victim always comes from the PLRU.

Decomposition:
- Shared package contents:
  - FSM state encoding: IDLE=0, REQ=1, WAIT=2, FILL=3.
  - WAY_NUM=4, WAY_IDX_W=2.
- One natural sub-module: way_pri_enc4, a 4-bit lowest-set-bit encoder with index, any and multi outputs.
  - Reused for hit-index encoding.
  - Reused for invalid-way selection.
- All state and data registers use the gnrl_dfflr flop.

Test Plan:
- Hit: vld=1, hit_vec=4'b0100 -> same cycle o_plru_hit=1, idx=2, o_plru_req=0, rdy stays 1, no mem req.
- Miss: vld=1, hit_vec=0, replace_idx=3, addr=0x1000:
  - Same cycle o_plru_req=1.
  - Next cycle mem_req_vld=1, addr=0x1000.
  - With rdy=1 and rsp one cycle later, data=0xA5.., the fill strobe has way=3, addr=0x1000, data=0xA5..; then rdy=1.
- Backpressure: hold i_mem_req_rdy=0 for 5 cycles -> req_vld and addr stable, o_lkup_rdy=0 throughout, a lookup presented meanwhile is not accepted and produces no PLRU pulse.
- Multi-hit: hit_vec=4'b0110 -> hit idx=1, o_multi_hit_err=1, and it stays 1 after subsequent clean hits until rst_n low.
- Reset in WAIT: assert rst_n=0, then release; a late rsp_vld -> no fill strobe, state IDLE, rdy=1.
- With WAY_REFILL_INVALID_FIRST_EN: way_valid=4'b1011 on a miss -> o_plru_hit=1, idx=2, o_plru_req=0, fill way=2. With way_valid=4'b1111 -> plru_req path, victim = replace_idx.

Source files
------------

// File: rtl/way_refill_ctrl_pkg.sv
// Shared constants for the way refill controller: way geometry and FSM encoding.
package way_refill_ctrl_pkg;

    localparam int WAY_NUM   = 4;
    localparam int WAY_IDX_W = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_FILL = 2'd3;

    typedef logic [WAY_IDX_W-1:0] way_idx_t;

endpackage

// File: rtl/gnrl_dfflr.sv
// Generic load-enabled flop with asynchronous active-low reset to zero.
module gnrl_dfflr #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qout <= '0;
        end else if (lden) begin
            qout <= dnxt;
        end
    end

endmodule

// File: rtl/way_refill_ctrl_pri_enc4.sv
// 4-bit lowest-set-bit encoder; also flags any-set and more-than-one-set.
module way_pri_enc4
    import way_refill_ctrl_pkg::*;
(
    input  logic [WAY_NUM-1:0] vec,
    output way_idx_t           idx,
    output logic               any,
    output logic               multi
);

    // Scan high to low so the lowest set bit wins.
    always_comb begin
        idx = '0;
        for (int i = WAY_NUM - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = WAY_IDX_W'(i);
            end
        end
    end

    assign any   = |vec;
    assign multi = |(vec & (vec - WAY_NUM'(1)));

endmodule

// File: rtl/way_refill_ctrl.sv
// Blocking miss/refill controller for a 4-way set array, driving the PLRU and a refill channel.
// Optional macro WAY_REFILL_INVALID_FIRST_EN: on a miss, prefer the lowest invalid way over the PLRU victim.
module way_refill_ctrl
    import way_refill_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_lkup_vld,
    input  logic [ADDR_WIDTH-1:0] i_lkup_addr,
    input  logic [WAY_NUM-1:0]    i_lkup_hit_vec,
`ifdef WAY_REFILL_INVALID_FIRST_EN
    input  logic [WAY_NUM-1:0]    i_way_valid,
`endif
    output logic                  o_lkup_rdy,
    output logic                  o_plru_hit,
    output logic [WAY_IDX_W-1:0]  o_plru_hit_idx,
    output logic                  o_plru_req,
    input  logic [WAY_IDX_W-1:0]  i_plru_replace_idx,
    output logic                  o_mem_req_vld,
    output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
    input  logic                  i_mem_req_rdy,
    input  logic                  i_mem_rsp_vld,
    input  logic [LINE_WIDTH-1:0] i_mem_rsp_data,
    output logic                  o_fill_vld,
    output logic [WAY_IDX_W-1:0]  o_fill_way,
    output logic [ADDR_WIDTH-1:0] o_fill_addr,
    output logic [LINE_WIDTH-1:0] o_fill_data,
    output logic                  o_multi_hit_err
);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic                  is_idle;
    logic                  is_req;
    logic                  is_wait;
    logic                  is_fill;
    logic                  lkup_acc;
    logic                  miss_acc;
    logic                  rsp_load;
    way_idx_t              hit_idx;
    logic                  hit_any;
    logic                  hit_multi;
    way_idx_t              victim_nxt;
    way_idx_t              victim;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] data_q;
    logic                  err_q;

    assign is_idle  = (state == ST_IDLE);
    assign is_req   = (state == ST_REQ);
    assign is_wait  = (state == ST_WAIT);
    assign is_fill  = (state == ST_FILL);

    assign lkup_acc = i_lkup_vld & is_idle;
    assign miss_acc = lkup_acc & ~hit_any;
    // Responses outside WAIT (e.g. before the request handshake) are dropped.
    assign rsp_load = is_wait & i_mem_rsp_vld;

    way_pri_enc4 u_hit_enc (
        .vec   (i_lkup_hit_vec),
        .idx   (hit_idx),
        .any   (hit_any),
        .multi (hit_multi)
    );

`ifdef WAY_REFILL_INVALID_FIRST_EN
    way_idx_t inv_idx;
    logic     inv_any;
    logic     inv_multi;

    way_pri_enc4 u_inv_enc (
        .vec   (~i_way_valid),
        .idx   (inv_idx),
        .any   (inv_any),
        .multi (inv_multi)
    );

    // An invalid victim is reported as a hit so the PLRU marks it MRU.
    assign o_plru_hit     = (lkup_acc & hit_any) | (miss_acc & inv_any);
    assign o_plru_hit_idx = hit_any ? hit_idx : inv_idx;
    assign o_plru_req     = miss_acc & ~inv_any;
    assign victim_nxt     = inv_any ? inv_idx : i_plru_replace_idx;
`else
    assign o_plru_hit     = lkup_acc & hit_any;
    assign o_plru_hit_idx = hit_idx;
    assign o_plru_req     = miss_acc;
    assign victim_nxt     = i_plru_replace_idx;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (miss_acc)      state_nxt = ST_REQ;
            ST_REQ:  if (i_mem_req_rdy) state_nxt = ST_WAIT;
            ST_WAIT: if (i_mem_rsp_vld) state_nxt = ST_FILL;
            ST_FILL:                    state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    gnrl_dfflr #(.DW(2)) u_state (
        .clk (clk), .rst_n (rst_n), .lden (1'b1), .dnxt (state_nxt), .qout (state)
    );

    // Victim is sampled before the PLRU updates at this same edge.
    gnrl_dfflr #(.DW(WAY_IDX_W)) u_victim (
        .clk (clk), .rst_n (rst_n), .lden (miss_acc), .dnxt (victim_nxt), .qout (victim)
    );

    gnrl_dfflr #(.DW(ADDR_WIDTH)) u_addr (
        .clk (clk), .rst_n (rst_n), .lden (miss_acc), .dnxt (i_lkup_addr), .qout (addr_q)
    );

    gnrl_dfflr #(.DW(LINE_WIDTH)) u_data (
        .clk (clk), .rst_n (rst_n), .lden (rsp_load), .dnxt (i_mem_rsp_data), .qout (data_q)
    );

    gnrl_dfflr #(.DW(1)) u_err (
        .clk (clk), .rst_n (rst_n), .lden (lkup_acc & hit_multi), .dnxt (1'b1), .qout (err_q)
    );

    assign o_lkup_rdy      = is_idle;
    assign o_mem_req_vld   = is_req;
    assign o_mem_req_addr  = addr_q;
    assign o_fill_vld      = is_fill;
    assign o_fill_way      = victim;
    assign o_fill_addr     = addr_q;
    assign o_fill_data     = data_q;
    assign o_multi_hit_err = err_q;

endmodule

// File: tb/tb_way_refill_ctrl.sv
// Self-checking bench for way_refill_ctrl: queued PLRU/fill expectations checked by a negedge monitor.
module tb_way_refill_ctrl;

    localparam int AW = 32;
    localparam int LW = 128;

    typedef struct {
        logic       hit;
        logic [1:0] idx;
    } plru_exp_t;

    typedef struct {
        logic [1:0]    way;
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
        int            cyc;
    } fill_exp_t;

    logic          clk;
    logic          rst_n;
    logic          lkup_vld;
    logic [AW-1:0] lkup_addr;
    logic [3:0]    hit_vec;
    logic [3:0]    way_valid;
    logic [1:0]    replace_idx;
    logic          mem_req_rdy;
    logic          mem_rsp_vld;
    logic [LW-1:0] mem_rsp_data;

    logic          o_lkup_rdy;
    logic          o_plru_hit;
    logic [1:0]    o_plru_hit_idx;
    logic          o_plru_req;
    logic          o_mem_req_vld;
    logic [AW-1:0] o_mem_req_addr;
    logic          o_fill_vld;
    logic [1:0]    o_fill_way;
    logic [AW-1:0] o_fill_addr;
    logic [LW-1:0] o_fill_data;
    logic          o_multi_hit_err;

    plru_exp_t plru_q[$];
    fill_exp_t fill_q[$];
    int        n_tests = 0;
    int        n_fail  = 0;
    int        cyc     = 0;
    logic      err_m   = 1'b0;
    logic      mon_en  = 1'b0;

    way_refill_ctrl #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_lkup_vld         (lkup_vld),
        .i_lkup_addr        (lkup_addr),
        .i_lkup_hit_vec     (hit_vec),
`ifdef WAY_REFILL_INVALID_FIRST_EN
        .i_way_valid        (way_valid),
`endif
        .o_lkup_rdy         (o_lkup_rdy),
        .o_plru_hit         (o_plru_hit),
        .o_plru_hit_idx     (o_plru_hit_idx),
        .o_plru_req         (o_plru_req),
        .i_plru_replace_idx (replace_idx),
        .o_mem_req_vld      (o_mem_req_vld),
        .o_mem_req_addr     (o_mem_req_addr),
        .i_mem_req_rdy      (mem_req_rdy),
        .i_mem_rsp_vld      (mem_rsp_vld),
        .i_mem_rsp_data     (mem_rsp_data),
        .o_fill_vld         (o_fill_vld),
        .o_fill_way         (o_fill_way),
        .o_fill_addr        (o_fill_addr),
        .o_fill_data        (o_fill_data),
        .o_multi_hit_err    (o_multi_hit_err)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference rules: lowest set bit, and victim choice on a miss.
    function automatic logic [1:0] lowest_bit(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    function automatic logic [2:0] exp_victim(input logic [3:0] wv, input logic [1:0] rep);
`ifdef WAY_REFILL_INVALID_FIRST_EN
        for (int i = 0; i < 4; i++) begin
            if (!wv[i]) return {1'b1, 2'(i)};
        end
`endif
        return {1'b0, rep};
    endfunction

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: pops expectations whenever the DUT presents a PLRU pulse or fill strobe.
    plru_exp_t mon_pe;
    fill_exp_t mon_fe;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("multi_hit_err", o_multi_hit_err, err_m);
            chk("plru_exclusive", o_plru_hit & o_plru_req, 0);
            if (o_plru_hit || o_plru_req) begin
                if (plru_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_plru: hit=%0b req=%0b idx=%0d with nothing expected (cycle %0d)",
                             o_plru_hit, o_plru_req, o_plru_hit_idx, cyc);
                end else begin
                    mon_pe = plru_q.pop_front();
                    chk("plru_hit", o_plru_hit, mon_pe.hit);
                    chk("plru_req", o_plru_req, !mon_pe.hit);
                    if (mon_pe.hit) chk("plru_hit_idx", o_plru_hit_idx, mon_pe.idx);
                end
            end
            if (o_fill_vld) begin
                if (fill_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_fill: way=%0d addr=%0h with nothing expected (cycle %0d)",
                             o_fill_way, o_fill_addr, cyc);
                end else begin
                    mon_fe = fill_q.pop_front();
                    chk("fill_way", o_fill_way, mon_fe.way);
                    chk("fill_addr", o_fill_addr, mon_fe.addr);
                    chk("fill_data", o_fill_data, mon_fe.data);
                    chk("fill_cycle", cyc, mon_fe.cyc);
                end
            end
        end
    end

    // Driver tasks: entered at posedge+1 with the DUT idle, leave at posedge+1 with it idle.
    task automatic do_hit(input logic [3:0] hv, input logic [AW-1:0] a);
        plru_exp_t pe;
        pe.hit = 1'b1;
        pe.idx = lowest_bit(hv);
        plru_q.push_back(pe);
        lkup_vld    = 1'b1;
        hit_vec     = hv;
        lkup_addr   = a;
        replace_idx = 2'($urandom_range(0, 3));
        way_valid   = 4'($urandom_range(0, 15));
        @(negedge clk);
        chk("hit_lkup_rdy", o_lkup_rdy, 1);
        chk("hit_no_mem_req", o_mem_req_vld, 0);
        @(posedge clk); #1;
        if ($countones(hv) > 1) err_m = 1'b1;
        lkup_vld = 1'b0;
    endtask

    task automatic do_miss(input logic [AW-1:0] a, input logic [1:0] rep, input logic [3:0] wv,
                           input int rdy_dly, input int rsp_dly, input logic [LW-1:0] d);
        logic [2:0] v;
        plru_exp_t  pe;
        fill_exp_t  fe;
        v       = exp_victim(wv, rep);
        pe.hit  = v[2];
        pe.idx  = v[1:0];
        plru_q.push_back(pe);
        fe.way  = v[1:0];
        fe.addr = a;
        fe.data = d;
        fe.cyc  = cyc + 3 + rdy_dly + rsp_dly;
        fill_q.push_back(fe);
        lkup_vld    = 1'b1;
        lkup_addr   = a;
        hit_vec     = 4'b0000;
        replace_idx = rep;
        way_valid   = wv;
        @(negedge clk);
        chk("miss_lkup_rdy", o_lkup_rdy, 1);
        @(posedge clk); #1;
        // REQ: stall rdy_dly cycles while unrelated lookups and junk data arrive.
        for (int i = 0; i <= rdy_dly; i++) begin
            mem_req_rdy  = (i == rdy_dly);
            lkup_vld     = 1'($urandom_range(0, 1));
            hit_vec      = 4'($urandom_range(0, 15));
            lkup_addr    = $urandom;
            replace_idx  = 2'($urandom_range(0, 3));
            mem_rsp_data = rand_line();
            @(negedge clk);
            chk("req_vld", o_mem_req_vld, 1);
            chk("req_addr", o_mem_req_addr, a);
            chk("busy_lkup_rdy", o_lkup_rdy, 0);
            @(posedge clk); #1;
        end
        mem_req_rdy = 1'b0;
        lkup_vld    = 1'b0;
        for (int i = 0; i < rsp_dly; i++) begin
            mem_rsp_data = rand_line();
            @(negedge clk);
            chk("wait_no_req", o_mem_req_vld, 0);
            @(posedge clk); #1;
        end
        mem_rsp_vld  = 1'b1;
        mem_rsp_data = d;
        @(posedge clk); #1;
        mem_rsp_vld  = 1'b0;
        mem_rsp_data = rand_line();
        @(posedge clk); #1;
    endtask

    task automatic reset_in_wait();
        plru_exp_t pe;
        pe.hit = 1'b0;
        pe.idx = 2'd1;
        plru_q.push_back(pe);
        lkup_vld    = 1'b1;
        lkup_addr   = 32'h0000_2040;
        hit_vec     = 4'b0000;
        replace_idx = 2'd1;
        way_valid   = 4'hF;
        @(posedge clk); #1;
        lkup_vld    = 1'b0;
        mem_req_rdy = 1'b1;
        @(posedge clk); #1;
        mem_req_rdy = 1'b0;
        @(negedge clk);
        chk("wait_lkup_rdy", o_lkup_rdy, 0);
        #1;
        rst_n = 1'b0;
        err_m = 1'b0;
        #2;
        chk("rst_lkup_rdy", o_lkup_rdy, 1);
        chk("rst_fill_vld", o_fill_vld, 0);
        chk("rst_req_vld", o_mem_req_vld, 0);
        @(posedge clk); #1;
        rst_n        = 1'b1;
        mem_rsp_vld  = 1'b1;
        mem_rsp_data = rand_line();
        @(posedge clk); #1;
        mem_rsp_vld = 1'b0;
        @(negedge clk);
        chk("late_rsp_no_fill", o_fill_vld, 0);
        chk("late_rsp_lkup_rdy", o_lkup_rdy, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n        = 1'b1;
        lkup_vld     = 1'b0;
        lkup_addr    = '0;
        hit_vec      = '0;
        way_valid    = 4'hF;
        replace_idx  = '0;
        mem_req_rdy  = 1'b0;
        mem_rsp_vld  = 1'b0;
        mem_rsp_data = '0;
        #2 rst_n = 1'b0;
        #2;
        chk("reset_lkup_rdy", o_lkup_rdy, 1);
        chk("reset_plru_hit", o_plru_hit, 0);
        chk("reset_plru_req", o_plru_req, 0);
        chk("reset_req_vld", o_mem_req_vld, 0);
        chk("reset_req_addr", o_mem_req_addr, 0);
        chk("reset_fill_vld", o_fill_vld, 0);
        chk("reset_fill_way", o_fill_way, 0);
        chk("reset_fill_addr", o_fill_addr, 0);
        chk("reset_fill_data", o_fill_data, 0);
        chk("reset_multi_err", o_multi_hit_err, 0);
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        do_hit(4'b0100, 32'h0000_0800);
        do_miss(32'h0000_1000, 2'd3, 4'hF, 0, 0, {4{32'hA5A5_A5A5}});
        do_miss(32'h0000_3300, 2'd0, 4'hF, 5, 1, rand_line());
        do_hit(4'b0110, 32'h0000_0440);
        do_hit(4'b0001, 32'h0000_0450);
        do_hit(4'b1000, 32'h0000_0460);
        reset_in_wait();
        do_hit(4'b0010, 32'h0000_0470);
`ifdef WAY_REFILL_INVALID_FIRST_EN
        do_miss(32'h0000_5000, 2'd0, 4'b1011, 1, 0, rand_line());
        do_miss(32'h0000_5100, 2'd1, 4'b1111, 0, 2, rand_line());
`endif

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                do_hit(4'($urandom_range(1, 15)), $urandom);
            end else begin
                do_miss($urandom, 2'($urandom_range(0, 3)),
                        ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15)),
                        $urandom_range(0, 3), $urandom_range(0, 3), rand_line());
            end
            if ($urandom_range(0, 3) == 0) begin
                hit_vec = 4'($urandom_range(0, 15));
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        chk("plru_q_drained", plru_q.size(), 0);
        chk("fill_q_drained", fill_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
